// File: rtl/bus_xbar_pkg.sv
// bus_xbar_pkg: memory bus types, SoC address map and interconnect constants.
package bus_xbar_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;
  localparam mem_in_type init_mem_in = '0;
  localparam mem_out_type init_mem_out = '0;
  localparam logic [31:0] rom_base_addr = 32'h0000_0000;
  localparam logic [31:0] rom_top_addr = 32'h0001_0000;
  localparam logic [31:0] ram_base_addr = 32'h8000_0000;
  localparam logic [31:0] ram_top_addr = 32'h8010_0000;
  localparam logic [31:0] tim_base_addr = 32'h0100_0000;
  localparam logic [31:0] tim_top_addr = 32'h0100_1000;
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr = 32'h0200_C000;
  localparam logic [31:0] uart_rx_base_addr = 32'h1000_0000;
  localparam logic [31:0] uart_rx_top_addr = 32'h1000_0010;
  localparam logic [31:0] uart_tx_base_addr = 32'h1000_0010;
  localparam logic [31:0] uart_tx_top_addr = 32'h1000_0020;
  localparam int bus_slv_num = 6;
  localparam logic [31:0] bus_base_addr [bus_slv_num] = '{rom_base_addr, ram_base_addr,
    tim_base_addr, clint_base_addr, uart_rx_base_addr, uart_tx_base_addr};
  localparam logic [31:0] bus_top_addr [bus_slv_num] = '{rom_top_addr, ram_top_addr,
    tim_top_addr, clint_top_addr, uart_rx_top_addr, uart_tx_top_addr};
  localparam int bus_timeout = 1024;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} xbar_state_type;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_decode.sv
// bus_decode: table-driven address decode with lowest-index priority and base-offset subtraction.
module bus_decode
  import bus_xbar_pkg::*;
#(
  parameter int N_SLV = bus_slv_num,
  parameter logic [31:0] BASE_ADDR [N_SLV] = bus_base_addr,
  parameter logic [31:0] TOP_ADDR [N_SLV] = bus_top_addr
) (
  input  logic [31:0]              addr,
  input  logic [N_SLV-1:0]         stale,
  output logic                     hit,
  output logic [idx_w(N_SLV)-1:0]  index,
  output logic [31:0]              offset
);
  localparam int IDX_W = idx_w(N_SLV);
  logic any;
  always_comb begin
    any = 1'b0;
    index = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int i = N_SLV - 1; i >= 0; i--)
      if (addr >= BASE_ADDR[i] && addr < TOP_ADDR[i]) begin
        any = 1'b1;
        index = IDX_W'(i);
      end
    hit = any && !stale[index];
    offset = addr - BASE_ADDR[index];
  end
endmodule

// File: rtl/bus_xbar.sv
// bus_xbar: single-master, N-slave interconnect with owner-tracked responses,
// decode-error responder, transaction timeout and stale-slave protection.
module bus_xbar
  import bus_xbar_pkg::*;
#(
  parameter int N_SLV = bus_slv_num,
  parameter logic [31:0] BASE_ADDR [N_SLV] = bus_base_addr,
  parameter logic [31:0] TOP_ADDR [N_SLV] = bus_top_addr,
  parameter int TIMEOUT = bus_timeout
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  mst_in,
  output mem_out_type mst_out,
  output mem_in_type  slv_in [N_SLV],
  input  mem_out_type slv_out [N_SLV],
  output logic        busy,
  output logic        timeout_evt,
  output logic        overlap_err
);
  localparam int IDX_W = idx_w(N_SLV);
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam mem_out_type ERR_RSP = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
  xbar_state_type   state;
  logic [IDX_W-1:0] owner, index;
  logic [CNT_W-1:0] cnt;
  logic [N_SLV-1:0] stale, rdy;
  mem_out_type      err_rsp;
  mem_in_type       fwd;
  logic [31:0]      offset;
  logic             hit, own_rdy, accept, tmo;
  bus_decode #(.N_SLV(N_SLV), .BASE_ADDR(BASE_ADDR), .TOP_ADDR(TOP_ADDR)) u_decode (
    .addr(mst_in.mem_addr), .stale(stale), .hit(hit), .index(index), .offset(offset)
  );
  for (genvar i = 0; i < N_SLV; i++) begin : g_slv
    assign rdy[i] = slv_out[i].mem_ready;
    assign slv_in[i] = (accept && hit && index == IDX_W'(i)) ? fwd : init_mem_in;
  end
  always_comb begin
    fwd = mst_in;
    fwd.mem_addr = offset;
  end
  assign own_rdy = state == BUSY && rdy[owner];
  // reset gates acceptance so nothing is forwarded while reset is held
  assign accept = reset && mst_in.mem_valid && (state != BUSY || own_rdy);
  assign tmo = TIMEOUT != 0 && state == BUSY && !own_rdy && cnt == CNT_W'(TIMEOUT - 1);
  assign mst_out = own_rdy ? slv_out[owner] : err_rsp;
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      cnt <= '0;
      stale <= '0;
      err_rsp <= init_mem_out;
      timeout_evt <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      // a stale slave's late ready is consumed here and never reaches mst_out
      stale <= (stale & ~rdy) | (tmo ? N_SLV'(1) << owner : '0);
      timeout_evt <= tmo;
      cnt <= accept ? '0 : cnt + 1'b1;
      if (state == BUSY && mst_in.mem_valid && !own_rdy) overlap_err <= 1'b1;
      if (accept && hit) owner <= index;
      err_rsp <= ((accept && !hit) || tmo) ? ERR_RSP : init_mem_out;
      state <= accept ? (hit ? BUSY : ERR) :
               (own_rdy || state == ERR) ? IDLE :
               tmo ? ERR : state;
    end
  end
endmodule
